// File: rtl/vram_pkg.sv
// Shared types and default widths for the vector-RAM port arbiter.
package vram_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned STREAK_W = 3;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VG
  } owner_t;

endpackage

// File: rtl/vram_clear_seq.sv
// Zero-fill address sequencer: walks every RAM address once per clk_en cycle.
module vram_clear_seq
  import vram_pkg::*;
#(
  parameter int unsigned ADDR = ADDR_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk_en,
  input  logic            start,
  output logic            busy,
  output logic [ADDR-1:0] addr,
  output logic            done_c
);

  localparam logic [ADDR-1:0] LAST_ADDR = '1;

  // Final write of the sweep happens in this cycle.
  assign done_c = clk_en & busy & (addr == LAST_ADDR);

  // Counter and busy flag; start is ignored while a sweep is running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      addr <= '0;
    end else if (clk_en) begin
      if (busy) begin
        addr <= addr + ADDR'(1);
        if (addr == LAST_ADDR) busy <= 1'b0;
      end else if (start) begin
        busy <= 1'b1;
        addr <= '0;
      end
    end
  end

endmodule

// File: rtl/vram_port_arb.sv
// CPU / vector-generator arbiter in front of the single-port vector RAM,
// with read-data return routing and a full-RAM clear engine.
// Build option: VRAM_PORT_ARB_FAIR_EN forces a VG slot after CPU_STREAK
// consecutive contended CPU wins; without it the CPU has strict priority.
module vram_port_arb
  import vram_pkg::*;
#(
  parameter int unsigned DATA = DATA_W,
  parameter int unsigned ADDR = ADDR_W
`ifdef VRAM_PORT_ARB_FAIR_EN
  ,
  parameter int unsigned CPU_STREAK = 4
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk_en,
  input  logic            cpu_req,
  input  logic            cpu_wr,
  input  logic [ADDR-1:0] cpu_addr,
  input  logic [DATA-1:0] cpu_din,
  output logic            cpu_ack,
  output logic            cpu_rvalid,
  output logic [DATA-1:0] cpu_dout,
  input  logic            vg_req,
  input  logic [ADDR-1:0] vg_addr,
  output logic            vg_ack,
  output logic            vg_rvalid,
  output logic [DATA-1:0] vg_dout,
  input  logic            clr_start,
  output logic            clr_busy,
  output logic            ram_en,
  output logic            ram_wr,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_din,
  input  logic [DATA-1:0] ram_dout
);

  arb_state_t      state;
  owner_t          pend;
  logic [ADDR-1:0] clr_addr;
  logic            clr_done_c;
  logic            grant_cpu_c;
  logic            grant_vg_c;
  logic            force_vg_c;
  logic            idle_slot_c;
  logic [DATA-1:0] cpu_hold;
  logic [DATA-1:0] vg_hold;

  vram_clear_seq #(
    .ADDR (ADDR)
  ) u_clear_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (clr_start & (state == ST_IDLE)),
    .busy    (clr_busy),
    .addr    (clr_addr),
    .done_c  (clr_done_c)
  );

  assign idle_slot_c = reset_n & clk_en & (state == ST_IDLE);

`ifdef VRAM_PORT_ARB_FAIR_EN
  logic [STREAK_W-1:0] streak;

  assign force_vg_c = (streak >= STREAK_W'(CPU_STREAK));

  // Count contended CPU wins; any other arbitration outcome restarts the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak <= '0;
    end else if (idle_slot_c) begin
      if (grant_cpu_c && vg_req) streak <= streak + STREAK_W'(1);
      else                       streak <= '0;
    end
  end
`else
  assign force_vg_c = 1'b0;
`endif

  // Pick at most one winner per enabled IDLE cycle.
  always_comb begin
    grant_cpu_c = 1'b0;
    grant_vg_c  = 1'b0;
    if (idle_slot_c) begin
      if (cpu_req && !(vg_req && force_vg_c)) grant_cpu_c = 1'b1;
      else if (vg_req)                        grant_vg_c  = 1'b1;
    end
  end

  // Drive the RAM port from the clear engine or the winning requester.
  always_comb begin
    ram_en   = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (clk_en && state == ST_CLEAR) begin
      ram_en   = 1'b1;
      ram_wr   = 1'b1;
      ram_addr = clr_addr;
    end else if (grant_cpu_c) begin
      ram_en   = 1'b1;
      ram_wr   = cpu_wr;
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
    end else if (grant_vg_c) begin
      ram_en   = 1'b1;
      ram_addr = vg_addr;
    end
  end

  assign cpu_ack    = grant_cpu_c;
  assign vg_ack     = grant_vg_c;
  assign cpu_rvalid = clk_en & (pend == OWN_CPU);
  assign vg_rvalid  = clk_en & (pend == OWN_VG);
  assign cpu_dout   = cpu_rvalid ? ram_dout : cpu_hold;
  assign vg_dout    = vg_rvalid  ? ram_dout : vg_hold;

  // Arbiter state: leave IDLE on a clear command, return after the last write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      case (state)
        ST_IDLE:  if (clr_start)  state <= ST_CLEAR;
        ST_CLEAR: if (clr_done_c) state <= ST_IDLE;
        default:                  state <= ST_IDLE;
      endcase
    end
  end

  // Owner tag of the read in flight; survives clk_en=0 gaps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= OWN_NONE;
    end else if (clk_en) begin
      if (grant_cpu_c && !cpu_wr) pend <= OWN_CPU;
      else if (grant_vg_c)        pend <= OWN_VG;
      else                        pend <= OWN_NONE;
    end
  end

  // Per-requester hold of the last returned read word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_hold <= '0;
      vg_hold  <= '0;
    end else begin
      if (cpu_rvalid) cpu_hold <= ram_dout;
      if (vg_rvalid)  vg_hold  <= ram_dout;
    end
  end

endmodule

// File: tb/tb_vram_port_arb.sv
// Directed bench for vram_port_arb with a behavioural single-port RAM.
module tb_vram_port_arb;

  localparam int unsigned DATA = 8;
  localparam int unsigned ADDR = 10;
  localparam int unsigned DEPTH = 1 << ADDR;

  logic            clk;
  logic            reset_n;
  logic            clk_en;
  logic            cpu_req;
  logic            cpu_wr;
  logic [ADDR-1:0] cpu_addr;
  logic [DATA-1:0] cpu_din;
  logic            cpu_ack;
  logic            cpu_rvalid;
  logic [DATA-1:0] cpu_dout;
  logic            vg_req;
  logic [ADDR-1:0] vg_addr;
  logic            vg_ack;
  logic            vg_rvalid;
  logic [DATA-1:0] vg_dout;
  logic            clr_start;
  logic            clr_busy;
  logic            ram_en;
  logic            ram_wr;
  logic [ADDR-1:0] ram_addr;
  logic [DATA-1:0] ram_din;
  logic [DATA-1:0] ram_dout;

  logic [DATA-1:0] mem [DEPTH];
  logic [DATA-1:0] ram_q;

  int n_checks;
  int n_pass;

  vram_port_arb dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_en     (clk_en),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_ack    (cpu_ack),
    .cpu_rvalid (cpu_rvalid),
    .cpu_dout   (cpu_dout),
    .vg_req     (vg_req),
    .vg_addr    (vg_addr),
    .vg_ack     (vg_ack),
    .vg_rvalid  (vg_rvalid),
    .vg_dout    (vg_dout),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .ram_en     (ram_en),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read, gated by its clk_en.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) mem[ram_addr] <= ram_din;
      else        ram_q <= mem[ram_addr];
    end
  end
  assign ram_dout = ram_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_din = d;
    @(negedge clk);
    check("cpu_write_ack", 32'(cpu_ack), 32'd1);
    cyc();
    cpu_req = 1'b0; cpu_wr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [1:0] exp_grant;
    n_checks = 0;
    n_pass   = 0;
    ram_q    = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA'($urandom);
    reset_n = 1'b0; clk_en = 1'b1; clr_start = 1'b0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
    vg_req = 1'b0; vg_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_rvalid", {30'd0, cpu_rvalid, vg_rvalid}, 32'd0);
    check("rst_douts", {16'd0, cpu_dout, vg_dout}, 32'd0);

    // Full clear, with a CPU write stalled behind it
    reset_n = 1'b1;
    clr_start = 1'b1;
    @(negedge clk);
    check("clr_start_cycle_busy", 32'(clr_busy), 32'd0);
    cyc();
    clr_start = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'h155; cpu_din = 8'h3A;
    bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge clk);
      if (!(clr_busy && ram_en && ram_wr && ram_din == '0 &&
            ram_addr == ADDR'(i) && !cpu_ack && !vg_ack))
        bad++;
      cyc();
    end
    check("clear_sweep_bad_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    check("clear_done_busy", 32'(clr_busy), 32'd0);
    check("stalled_write_ack", 32'(cpu_ack), 32'd1);
    check("stalled_write_addr", 32'(ram_addr), 32'h155);
    check("stalled_write_din", {31'd0, ram_wr} | (32'(ram_din) << 8), 32'h3A01);
    cyc();
    cpu_req = 1'b0; cpu_wr = 1'b0;

    // CPU read-back of 0x155
    cpu_req = 1'b1; cpu_addr = 10'h155;
    @(negedge clk);
    check("cpu_rd_ack", {30'd0, cpu_ack, ram_wr}, 32'b10);
    cyc();
    cpu_req = 1'b0;
    @(negedge clk);
    check("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("cpu_dout", 32'(cpu_dout), 32'h3A);
    cyc();
    @(negedge clk);
    check("cpu_rvalid_pulse", 32'(cpu_rvalid), 32'd0);
    check("cpu_dout_hold", 32'(cpu_dout), 32'h3A);
    cyc();

    // Contention: CPU first, VG next, data returned in order
    cpu_write(10'h010, 8'h11);
    cpu_write(10'h020, 8'h22);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h010;
    vg_req = 1'b1; vg_addr = 10'h020;
    @(negedge clk);
    check("cont_grant0", {30'd0, cpu_ack, vg_ack}, 32'b10);
    check("cont_addr0", 32'(ram_addr), 32'h010);
    cyc();
    cpu_req = 1'b0;
    @(negedge clk);
    check("cont_grant1", {30'd0, cpu_ack, vg_ack}, 32'b01);
    check("cont_addr1", 32'(ram_addr), 32'h020);
    check("cont_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("cont_cpu_dout", 32'(cpu_dout), 32'h11);
    cyc();
    vg_req = 1'b0;
    @(negedge clk);
    check("cont_vg_rvalid", {30'd0, cpu_rvalid, vg_rvalid}, 32'b01);
    check("cont_vg_dout", 32'(vg_dout), 32'h22);
    cyc();

    // clk_en gaps after a VG read ack
    vg_req = 1'b1; vg_addr = 10'h010;
    @(negedge clk);
    check("gap_vg_ack", 32'(vg_ack), 32'd1);
    cyc();
    vg_req = 1'b0; clk_en = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'h3FF; cpu_din = 8'hEE;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("gap_quiet", {28'd0, cpu_ack, vg_ack, ram_en, vg_rvalid}, 32'd0);
      cyc();
    end
    cpu_req = 1'b0; cpu_wr = 1'b0; clk_en = 1'b1;
    @(negedge clk);
    check("gap_vg_rvalid", 32'(vg_rvalid), 32'd1);
    check("gap_vg_dout", 32'(vg_dout), 32'h11);
    cyc();

    // Reset in the middle of a clear
    cpu_write(10'h300, 8'h5C);
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    repeat (10'h200) cyc();
    @(negedge clk);
    check("midclr_addr", 32'(ram_addr), 32'h200);
    reset_n = 1'b0;
    #1;
    check("midclr_abort", {30'd0, clr_busy, ram_en}, 32'd0);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h300;
    cyc();
    check("rst_held_no_ack", 32'(cpu_ack), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ack", 32'(cpu_ack), 32'd1);
    check("post_rst_addr", 32'(ram_addr), 32'h300);
    cyc();
    cpu_req = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid", 32'(cpu_rvalid), 32'd1);
    check("post_rst_dout", 32'(cpu_dout), 32'h5C);
    cyc();

    // Continuous contention: grant pattern
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h010;
    vg_req = 1'b1; vg_addr = 10'h020;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
`ifdef VRAM_PORT_ARB_FAIR_EN
      exp_grant = ((k % 5) == 4) ? 2'b01 : 2'b10;
`else
      exp_grant = 2'b10;
`endif
      check($sformatf("grant_%0d", k), {30'd0, cpu_ack, vg_ack}, 32'(exp_grant));
      cyc();
    end
    cpu_req = 1'b0; vg_req = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_port_arb.md
Name: vram_port_arb

Overview:
- Request arbiter and sequencer placed directly upstream of the single-port vector RAM.
- Multiplexes two requesters onto the RAM's one clk_en-qualified port:
  - CPU bus: read/write.
  - Vector-generator fetch: read-only.
- Tracks the RAM's one-cycle registered read latency and returns read data to the requester that issued the read.
- Contains a clear engine that zero-fills the whole RAM on command, used at boot and on watchdog restart.

Parameters:
- DATA, 8, RAM word width.
- ADDR, 10, RAM address width; depth is 2**ADDR.
- CPU_STREAK, 4, consecutive contended CPU wins before the vector generator is forced a slot (optional feature only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; every state change and RAM access is qualified by it
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_wr  in  1  1=write, 0=read
- cpu_addr  in  ADDR  CPU address
- cpu_din  in  DATA  CPU write data
- cpu_ack  out  1  pulse: CPU access issued this cycle
- cpu_rvalid  out  1  pulse: CPU read data valid
- cpu_dout  out  DATA  CPU read data
- vg_req  in  1  vector-generator read request, held until vg_ack
- vg_addr  in  ADDR  vector-generator address
- vg_ack  out  1  pulse: vector-generator read issued
- vg_rvalid  out  1  pulse: vector-generator data valid
- vg_dout  out  DATA  vector-generator read data
- clr_start  in  1  start full-RAM clear
- clr_busy  out  1  clear in progress
- ram_en  out  1  to RAM clk_en
- ram_wr  out  1  to RAM wr
- ram_addr  out  ADDR  to RAM addr
- ram_din  out  DATA  to RAM din
- ram_dout  in  DATA  from RAM dout

Behaviour:
- Reset: all outputs 0. State IDLE, clear counter 0, hold registers 0.
- States:
  - IDLE → CLEAR on clr_start while clk_en=1.
  - CLEAR → IDLE in the clk_en cycle that writes address 2**ADDR-1.
  - clr_start while in CLEAR is ignored.
- Arbitration per clk_en cycle:
  - CLEAR state has absolute priority. It writes 0 to the counter address, counter +1, one address per clk_en cycle. clr_busy=1 throughout CLEAR.
  - In IDLE, CPU wins over the vector generator. At most one access is issued per cycle.
  - Issuing: ram_en=1, ram_addr/ram_wr/ram_din from the winner, and the winner's ack=1 in the same cycle. All ack outputs and ram_en are combinational and 0 when clk_en=0.
  - Requests are never acked while in CLEAR; requesters stall.
- Read latency:
  - A read issued in clk_en cycle N asserts that requester's rvalid in the next clk_en cycle N+1, with dout = ram_dout.
  - rvalid is a single-cycle pulse. It stays pending across clk_en=0 cycles and fires in the first clk_en=1 cycle.
  - dout is captured into a per-requester hold register when rvalid fires and stays stable until that requester's next read completes.
  - Writes produce no rvalid.
- Back-to-back reads (e.g. CPU in N, VG in N+1) are supported. The owner tag is registered per issued read.
- Reset asserted mid-clear: immediate abort, counter returns to 0, clr_busy=0. RAM contents are undefined.
- Reset asserted with a read in flight: the rvalid is dropped.

Optional Feature:
- Macro: VRAM_PORT_ARB_FAIR_EN.
- Defined:
  - A 3-bit streak counter increments on each cycle where the CPU wins while vg_req=1.
  - When the count reaches CPU_STREAK, the next contended slot goes to the vector generator and the counter resets.
  - The counter also resets on any uncontended cycle or any VG grant.
- Undefined: strict CPU priority; the CPU_STREAK parameter is unused.

Decomposition:
- Package vram_pkg:
  - arb_state_t enum {ST_IDLE, ST_CLEAR}.
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_VG}.
  - Default DATA/ADDR localparams.
- Sub-module vram_clear_seq: counter, busy flag, done pulse, taking clk_en, start and reset_n.

Test Plan:
- Reset, then clr_start with clk_en=1 continuous: clr_busy=1 for exactly 1024 cycles, ram_wr=1 with ram_din=0 at addresses 0..1023, then clr_busy=0.
- CPU write 0x3A to 0x155, then CPU read 0x155: cpu_ack on each request, cpu_rvalid one cycle after the read ack, cpu_dout=0x3A and held until the next CPU read completes.
- cpu_req and vg_req held together, CPU addr 0x010, VG addr 0x020: CPU acked first, VG acked the next cycle, cpu_rvalid then vg_rvalid on consecutive cycles with the correct data.
- clk_en toggling 1,0,0,1 after a VG read ack: vg_rvalid fires only in the fourth cycle. No acks and no ram_en occur while clk_en=0.
- reset_n low at clear address 0x200: clr_busy=0 immediately. After release, a CPU read is acked on the first clk_en cycle.
- With VRAM_PORT_ARB_FAIR_EN defined and CPU_STREAK=4, both requests held continuously: grant pattern is CPU×4, VG×1, repeating. Without the macro: CPU only.
